// File: rtl/fft_frame_reorder.sv
// rtl/fft_frame_reorder.sv - ping-pong frame buffer, natural-order write, bit-reversed (or natural) read
module fft_frame_reorder #(
    parameter int WIDTH      = 16,
    parameter int N_FFT      = 512,
    parameter int ADDR_WIDTH = $clog2(N_FFT),
    parameter int BIT_REV    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_en,
    input  logic             din_sof,
    input  logic [WIDTH-1:0] din_re,
    input  logic [WIDTH-1:0] din_im,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout_re,
    output logic [WIDTH-1:0] dout_im,
    output logic             dout_sof,
    output logic             dout_eof,
    output logic             frame_drop,
    output logic             ovf_err
);
    localparam int DW = 2 * WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_FFT - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
    typedef enum logic {R_IDLE, R_STREAM} r_state_t;
    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic             sof;
        logic             eof;
    } ent_t;

    logic [DW-1:0] bank0 [N_FFT];
    logic [DW-1:0] bank1 [N_FFT];
    logic [DW-1:0] q0, q1;
    logic [1:0]    full;
    logic          w_bank, w_bank_n, r_bank, rd_bank, rd_sel;

    w_state_t              w_state, w_state_n;
    logic [ADDR_WIDTH-1:0] w_cnt, w_cnt_n, wr_addr;
    logic                  wr_en, drop, ovf_set, fill_done;

    r_state_t              r_state, r_state_n;
    logic [ADDR_WIDTH-1:0] r_cnt, rd_addr;
    logic                  issue, last_issue, issue_ok;
    logic                  rd_valid, rd_sof, rd_eof;
    ent_t                  rd_ent, out_q, skid_q;
    logic                  out_valid, skid_valid, pop, release_bank;
    logic [1:0]            fill_lvl;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = a[ADDR_WIDTH-1-i];
        return r;
    endfunction

    always_comb begin
        w_state_n = w_state;
        w_cnt_n   = w_cnt;
        w_bank_n  = w_bank;
        wr_en     = 1'b0;
        wr_addr   = w_cnt;
        drop      = 1'b0;
        ovf_set   = 1'b0;
        fill_done = 1'b0;
        if (din_en) begin
            if (din_sof) begin
                // A sof while filling is a short frame: drop it and restart on this sample.
                if (w_state == W_FILL) drop = 1'b1;
                if (!full[w_bank]) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    w_cnt_n   = ADDR_WIDTH'(1);
                    w_state_n = W_FILL;
                end else begin
                    drop      = 1'b1;
                    ovf_set   = 1'b1;
                    w_state_n = W_DROP;
                end
            end else if (w_state == W_FILL) begin
                wr_en   = 1'b1;
                w_cnt_n = w_cnt + 1'b1;
                if (w_cnt == LAST_ADDR) begin
                    fill_done = 1'b1;
                    w_bank_n  = ~w_bank;
                    w_cnt_n   = '0;
                    w_state_n = W_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state    <= W_IDLE;
            w_cnt      <= '0;
            w_bank     <= 1'b0;
            frame_drop <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            w_state    <= w_state_n;
            w_cnt      <= w_cnt_n;
            w_bank     <= w_bank_n;
            frame_drop <= drop;
            ovf_err    <= ovf_err | ovf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !w_bank) bank0[wr_addr] <= {din_re, din_im};
        if (wr_en && w_bank)  bank1[wr_addr] <= {din_re, din_im};
        q0 <= bank0[rd_addr];
        q1 <= bank1[rd_addr];
    end

    assign pop          = out_valid && dout_ready;
    assign release_bank = pop && out_q.eof;
    assign rd_ent       = {(rd_sel ? q1 : q0), rd_sof, rd_eof};

    // Reads are issued only when the output+skid pair can absorb every read in flight.
    always_comb begin
        fill_lvl  = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_valid};
        issue_ok  = (fill_lvl < 2'd2) || (pop && fill_lvl == 2'd2);
        rd_addr   = (BIT_REV != 0) ? bitrev(r_cnt) : r_cnt;
        r_state_n = r_state;
        issue     = 1'b0;
        case (r_state)
            R_IDLE:   issue = full[rd_bank] && issue_ok;
            R_STREAM: issue = issue_ok;
            default:  issue = 1'b0;
        endcase
        last_issue = issue && (r_cnt == LAST_ADDR);
        if (issue) r_state_n = R_STREAM;
        // The issue pointer moves ahead of the release pointer so a queued bank follows with no gap.
        if (last_issue && !full[~rd_bank]) r_state_n = R_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= R_IDLE;
            r_cnt      <= '0;
            rd_bank    <= 1'b0;
            r_bank     <= 1'b0;
            rd_sel     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_sof     <= 1'b0;
            rd_eof     <= 1'b0;
            full       <= 2'b00;
            out_valid  <= 1'b0;
            out_q      <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else begin
            r_state  <= r_state_n;
            if (issue) r_cnt <= last_issue ? '0 : r_cnt + 1'b1;
            if (last_issue) rd_bank <= ~rd_bank;
            rd_sel   <= rd_bank;
            rd_valid <= issue;
            rd_sof   <= issue && (r_cnt == '0);
            rd_eof   <= last_issue;
            if (release_bank) r_bank <= ~r_bank;
            if (fill_done) full[w_bank] <= 1'b1;
            if (release_bank) full[r_bank] <= 1'b0;
            if (!out_valid || pop) begin
                if (skid_valid) begin
                    out_q      <= skid_q;
                    out_valid  <= 1'b1;
                    skid_valid <= rd_valid;
                    if (rd_valid) skid_q <= rd_ent;
                end else begin
                    out_valid <= rd_valid;
                    if (rd_valid) out_q <= rd_ent;
                end
            end else if (rd_valid) begin
                skid_valid <= 1'b1;
                skid_q     <= rd_ent;
            end
        end
    end

    assign dout_valid = out_valid;
    assign dout_re    = out_q.re;
    assign dout_im    = out_q.im;
    assign dout_sof   = out_q.sof;
    assign dout_eof   = out_q.eof;
endmodule
